// File: rtl/control_unit_fsm_pkg.sv
// Shared opcode, state and decode-class definitions for the multi-cycle control unit.
package control_unit_fsm_pkg;

   typedef enum logic [4:0] {
      OP_NOP = 5'd0,
      OP_LDR = 5'd1,
      OP_STR = 5'd2,
      OP_LDI = 5'd3,
      OP_MOV = 5'd4,
      OP_ADD = 5'd5,
      OP_SUB = 5'd6,
      OP_AND = 5'd7,
      OP_OR  = 5'd8,
      OP_XOR = 5'd9,
      OP_JMP = 5'd10,
      OP_JZ  = 5'd11,
      OP_JNZ = 5'd12,
      OP_JC  = 5'd13,
      OP_JNC = 5'd14,
      OP_HLT = 5'd31
   } opcode_e;

   typedef enum logic [3:0] {
      ST_FETCH_PC   = 4'd0,
      ST_FETCH_INST = 4'd1,
      ST_DECODE     = 4'd2,
      ST_MEM_R      = 4'd3,
      ST_MEM_W      = 4'd4,
      ST_ALU_FETCH  = 4'd5,
      ST_ALU_OUT    = 4'd6,
      ST_JMP        = 4'd7,
      ST_HALT       = 4'd8
   } state_e;

   typedef enum logic [2:0] {
      CLS_NOP,
      CLS_HLT,
      CLS_LDR,
      CLS_STR,
      CLS_LDI,
      CLS_MOV,
      CLS_ALU,
      CLS_JMP
   } op_class_e;

   typedef enum logic [2:0] {
      JC_ALWAYS,
      JC_Z,
      JC_NZ,
      JC_C,
      JC_NC
   } jcond_e;

   localparam logic [2:0] MOV_MODE_REG = 3'b010;
   localparam logic [2:0] MOV_MODE_MEM = 3'b011;

   function automatic logic jump_taken(input jcond_e cond, input logic z, input logic cy);
      logic taken;
      case (cond)
         JC_ALWAYS: taken = 1'b1;
         JC_Z:      taken = z;
         JC_NZ:     taken = ~z;
         JC_C:      taken = cy;
         JC_NC:     taken = ~cy;
         default:   taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational instruction decode: opcode class, jump condition and the
// register-select / data-address fields pulled out of the IR.
module cu_decode
   import control_unit_fsm_pkg::*;
#(
   parameter int INSTR_W   = 16,
   parameter int REG_SEL_W = 3,
   parameter int DADDR_W   = 8
) (
   input  logic [INSTR_W-1:0]   ir,
   output op_class_e            op_class,
   output jcond_e               jcond,
   output logic                 mov_reg,
   output logic                 mov_mem,
   output logic [DADDR_W-1:0]   dmar_addr,
   output logic [REG_SEL_W-1:0] sel_in,
   output logic [REG_SEL_W-1:0] sel_out,
   output logic                 imm_sel
);

   logic [4:0] opcode;
   logic [2:0] mode;

   assign opcode = ir[INSTR_W-1 -: 5];
   assign mode   = ir[INSTR_W-6 -: 3];

   always_comb begin
      op_class  = CLS_NOP;
      jcond     = JC_ALWAYS;
      mov_reg   = 1'b0;
      mov_mem   = 1'b0;
      dmar_addr = '0;
      sel_in    = '0;
      sel_out   = '0;
      imm_sel   = 1'b0;

      case (opcode)
         OP_HLT: op_class = CLS_HLT;
         OP_LDR: op_class = CLS_LDR;
         OP_STR: op_class = CLS_STR;
         OP_LDI: op_class = CLS_LDI;
         OP_MOV: op_class = CLS_MOV;
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: op_class = CLS_ALU;
         OP_JMP: begin op_class = CLS_JMP; jcond = JC_ALWAYS; end
         OP_JZ:  begin op_class = CLS_JMP; jcond = JC_Z;      end
         OP_JNZ: begin op_class = CLS_JMP; jcond = JC_NZ;     end
         OP_JC:  begin op_class = CLS_JMP; jcond = JC_C;      end
         OP_JNC: begin op_class = CLS_JMP; jcond = JC_NC;     end
         default: op_class = CLS_NOP;
      endcase

      mov_reg = (op_class == CLS_MOV) && (mode == MOV_MODE_REG);
      mov_mem = (op_class == CLS_MOV) && (mode == MOV_MODE_MEM);
      imm_sel = (op_class == CLS_LDI);

      if (mov_mem)
         dmar_addr = DADDR_W'(ir[4:0]);
      else if (op_class == CLS_LDR || op_class == CLS_STR)
         dmar_addr = ir[DADDR_W-1:0];

      // LDI always writes register 0; MOV writes the ir[7:5] field
      case (op_class)
         CLS_ALU, CLS_LDR: sel_in = REG_SEL_W'(ir[10:8]);
         CLS_MOV:          sel_in = REG_SEL_W'(ir[7:5]);
         default:          sel_in = '0;
      endcase

      case (op_class)
         CLS_ALU: sel_out = REG_SEL_W'(ir[7:5]);
         CLS_STR: sel_out = REG_SEL_W'(ir[10:8]);
         CLS_MOV: sel_out = mov_reg ? REG_SEL_W'(ir[4:2]) : '0;
         default: sel_out = '0;
      endcase
   end

endmodule

// File: rtl/control_unit_fsm.sv
// Multi-cycle control unit: fetch/decode/execute sequencer with memory ready
// handshakes, a bus-error timeout into HALT, and resume from HALT.
module control_unit_fsm
   import control_unit_fsm_pkg::*;
#(
   parameter int INSTR_W   = 16,
   parameter int REG_SEL_W = 3,
   parameter int DADDR_W   = 8,
   parameter int WAIT_MAX  = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [INSTR_W-1:0]   instr_in,
   input  logic                 i_ready,
   input  logic                 d_ready,
   input  logic                 cflag,
   input  logic                 zflag,
   input  logic                 resume,
   output logic                 pc_inc,
   output logic                 pc_load,
   output logic                 i_mar_we,
   output logic                 i_rd,
   output logic                 d_mar_we,
   output logic                 d_rd,
   output logic                 d_wr,
   output logic [DADDR_W-1:0]   dmar_addr,
   output logic                 alu_en,
   output logic                 alu_oe,
   output logic                 reg_re,
   output logic                 reg_we,
   output logic [REG_SEL_W-1:0] reg_sel_in,
   output logic [REG_SEL_W-1:0] reg_sel_out,
   output logic                 imm_sel,
   output logic                 halted,
   output logic                 bus_err,
   output logic [3:0]           state
);

   localparam int CNT_W = $clog2(WAIT_MAX + 1);

   state_e             state_q, state_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic               bus_err_q, bus_err_d;

   op_class_e             op_class;
   jcond_e                jcond;
   logic                  mov_reg, mov_mem;
   logic [REG_SEL_W-1:0]  dec_sel_in, dec_sel_out;

   logic pc_inc_s, pc_load_s, i_mar_we_s, i_rd_s, d_mar_we_s, d_rd_s, d_wr_s;
   logic alu_en_s, alu_oe_s, reg_re_s, reg_we_s;
   logic waiting, ready;

   cu_decode #(
      .INSTR_W   (INSTR_W),
      .REG_SEL_W (REG_SEL_W),
      .DADDR_W   (DADDR_W)
   ) u_decode (
      .ir        (ir_q),
      .op_class  (op_class),
      .jcond     (jcond),
      .mov_reg   (mov_reg),
      .mov_mem   (mov_mem),
      .dmar_addr (dmar_addr),
      .sel_in    (dec_sel_in),
      .sel_out   (dec_sel_out),
      .imm_sel   (imm_sel)
   );

   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      bus_err_d  = bus_err_q;
      pc_inc_s   = 1'b0;
      pc_load_s  = 1'b0;
      i_mar_we_s = 1'b0;
      i_rd_s     = 1'b0;
      d_mar_we_s = 1'b0;
      d_rd_s     = 1'b0;
      d_wr_s     = 1'b0;
      alu_en_s   = 1'b0;
      alu_oe_s   = 1'b0;
      reg_re_s   = 1'b0;
      reg_we_s   = 1'b0;
      waiting    = 1'b0;
      ready      = 1'b0;

      case (state_q)
         ST_FETCH_PC: begin
            pc_inc_s   = 1'b1;
            i_mar_we_s = 1'b1;
            state_d    = ST_FETCH_INST;
         end
         ST_FETCH_INST: begin
            i_rd_s  = 1'b1;
            waiting = 1'b1;
            ready   = i_ready;
            if (i_ready) begin
               ir_d    = instr_in;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            case (op_class)
               CLS_HLT:          state_d = ST_HALT;
               CLS_LDR, CLS_MOV: state_d = ST_MEM_R;
               CLS_ALU:          state_d = ST_ALU_FETCH;
               CLS_LDI, CLS_STR: state_d = ST_MEM_W;
               CLS_JMP:          state_d = ST_JMP;
               default:          state_d = ST_FETCH_PC;
            endcase
         end
         ST_MEM_R: begin
            d_mar_we_s = 1'b1;
            d_rd_s     = (op_class == CLS_LDR) || mov_mem;
            reg_re_s   = mov_reg;
            if (d_rd_s) begin
               waiting = 1'b1;
               ready   = d_ready;
               if (d_ready)
                  state_d = ST_MEM_W;
            end else begin
               state_d = ST_MEM_W;
            end
         end
         ST_MEM_W: begin
            d_mar_we_s = 1'b1;
            if (op_class == CLS_STR) begin
               d_wr_s   = 1'b1;
               reg_re_s = 1'b1;
               waiting  = 1'b1;
               ready    = d_ready;
               if (d_ready)
                  state_d = ST_FETCH_PC;
            end else begin
               reg_we_s = 1'b1;
               state_d  = ST_FETCH_PC;
            end
         end
         ST_ALU_FETCH: begin
            alu_en_s = 1'b1;
            reg_re_s = 1'b1;
            state_d  = ST_ALU_OUT;
         end
         ST_ALU_OUT: begin
            alu_oe_s = 1'b1;
            reg_we_s = 1'b1;
            state_d  = ST_FETCH_PC;
         end
         ST_JMP: begin
            if (jump_taken(jcond, zflag, cflag)) begin
               pc_load_s  = 1'b1;
               i_mar_we_s = 1'b1;
               state_d    = ST_FETCH_INST;
            end else begin
               state_d = ST_FETCH_PC;
            end
         end
         ST_HALT: begin
            if (resume)
               state_d = ST_FETCH_PC;
         end
         default: state_d = ST_FETCH_PC;
      endcase

      // The WAIT_MAX-th consecutive unanswered wait cycle is a bus error
      if (waiting && !ready && (wait_cnt_q == CNT_W'(WAIT_MAX - 1))) begin
         bus_err_d = 1'b1;
         state_d   = ST_HALT;
      end

      if (state_d != state_q)
         wait_cnt_d = '0;
      else if (waiting && !ready)
         wait_cnt_d = wait_cnt_q + CNT_W'(1);
      else
         wait_cnt_d = wait_cnt_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_FETCH_PC;
         ir_q       <= '0;
         wait_cnt_q <= '0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         wait_cnt_q <= wait_cnt_d;
         bus_err_q  <= bus_err_d;
      end
   end

   // Strobes are masked by the reset pin itself so they drop the instant reset asserts
   assign pc_inc      = pc_inc_s   & reset;
   assign pc_load     = pc_load_s  & reset;
   assign i_mar_we    = i_mar_we_s & reset;
   assign i_rd        = i_rd_s     & reset;
   assign d_mar_we    = d_mar_we_s & reset;
   assign d_rd        = d_rd_s     & reset;
   assign d_wr        = d_wr_s     & reset;
   assign alu_en      = alu_en_s   & reset;
   assign alu_oe      = alu_oe_s   & reset;
   assign reg_re      = reg_re_s   & reset;
   assign reg_we      = reg_we_s   & reset;
   assign reg_sel_in  = reg_we ? dec_sel_in  : '0;
   assign reg_sel_out = reg_re ? dec_sel_out : '0;
   assign halted      = (state_q == ST_HALT);
   assign bus_err     = bus_err_q;
   assign state       = state_q;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Scoreboard bench for control_unit_fsm: stimulus pushes hand-derived per-cycle
// expected outputs, an independent monitor pops and compares on each falling edge.
module tb_control_unit_fsm;

   logic        clk;
   logic        reset;
   logic [15:0] instr_in;
   logic        i_ready, d_ready, cflag, zflag, resume;
   logic        pc_inc, pc_load, i_mar_we, i_rd, d_mar_we, d_rd, d_wr;
   logic [7:0]  dmar_addr;
   logic        alu_en, alu_oe, reg_re, reg_we, imm_sel, halted, bus_err;
   logic [2:0]  reg_sel_in, reg_sel_out;
   logic [3:0]  state;

   control_unit_fsm #(
      .INSTR_W   (16),
      .REG_SEL_W (3),
      .DADDR_W   (8),
      .WAIT_MAX  (15)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .instr_in    (instr_in),
      .i_ready     (i_ready),
      .d_ready     (d_ready),
      .cflag       (cflag),
      .zflag       (zflag),
      .resume      (resume),
      .pc_inc      (pc_inc),
      .pc_load     (pc_load),
      .i_mar_we    (i_mar_we),
      .i_rd        (i_rd),
      .d_mar_we    (d_mar_we),
      .d_rd        (d_rd),
      .d_wr        (d_wr),
      .dmar_addr   (dmar_addr),
      .alu_en      (alu_en),
      .alu_oe      (alu_oe),
      .reg_re      (reg_re),
      .reg_we      (reg_we),
      .reg_sel_in  (reg_sel_in),
      .reg_sel_out (reg_sel_out),
      .imm_sel     (imm_sel),
      .halted      (halted),
      .bus_err     (bus_err),
      .state       (state)
   );

   localparam logic [3:0] S_FP = 4'd0, S_FI = 4'd1, S_DE = 4'd2, S_MR = 4'd3, S_MW = 4'd4;
   localparam logic [3:0] S_AF = 4'd5, S_AO = 4'd6, S_JM = 4'd7, S_HA = 4'd8;

   localparam logic [13:0] PINC = 14'h2000, PLD = 14'h1000, IMW = 14'h0800, IRD = 14'h0400;
   localparam logic [13:0] DMW  = 14'h0200, DRD = 14'h0100, DWR = 14'h0080, AEN = 14'h0040;
   localparam logic [13:0] AOE  = 14'h0020, RRE = 14'h0010, RWE = 14'h0008, IMM = 14'h0004;
   localparam logic [13:0] HLT  = 14'h0002, BER = 14'h0001;

   typedef struct packed {
      logic [7:0]  tid;
      logic [7:0]  step;
      logic [31:0] v;
      logic [31:0] m;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   logic [7:0] tid;
   logic [7:0] step;

   logic        n_rst, n_irdy, n_drdy, n_zf, n_cf, n_res;
   logic [15:0] n_ins;

   logic [31:0] got;
   assign got = {state, pc_inc, pc_load, i_mar_we, i_rd, d_mar_we, d_rd, d_wr, alu_en, alu_oe,
                 reg_re, reg_we, imm_sel, halted, bus_err, reg_sel_in, reg_sel_out, dmar_addr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ic=0 masks imm_sel and dmar_addr during fetch, where the IR still holds the previous instruction
   function automatic logic [63:0] ex(input logic [3:0] st, input logic [13:0] sbits,
                                      input logic [2:0] si, input logic [2:0] so,
                                      input logic [7:0] da, input logic ic);
      logic [31:0] v, m;
      v = {st, sbits, si, so, da};
      m = ic ? 32'hFFFF_FFFF : ~32'h0001_00FF;
      return {v, m};
   endfunction

   task automatic applyStimulus(input logic [63:0] e);
      exp_t x;
      @(posedge clk);
      #1;
      reset    = n_rst;
      instr_in = n_ins;
      i_ready  = n_irdy;
      d_ready  = n_drdy;
      zflag    = n_zf;
      cflag    = n_cf;
      resume   = n_res;
      x.tid  = tid;
      x.step = step;
      x.v    = e[63:32];
      x.m    = e[31:0];
      sb.push_back(x);
      step = step + 8'd1;
   endtask

   task automatic checkOutput(input exp_t x);
      total++;
      if ((got & x.m) !== (x.v & x.m)) begin
         bad++;
         $display("[TB] FAIL t%0d.%0d outputs got=%h want=%h mask=%h",
                  x.tid, x.step, got, x.v, x.m);
      end
   endtask

   task automatic newTest(input logic [7:0] t);
      tid  = t;
      step = 8'd0;
   endtask

   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            x = sb.pop_front();
            checkOutput(x);
         end
      end
   end

   initial begin
      reset = 1'b0; instr_in = '0; i_ready = 1'b1; d_ready = 1'b0;
      cflag = 1'b0; zflag = 1'b0; resume = 1'b0;
      n_rst = 1'b0; n_ins = '0; n_irdy = 1'b1; n_drdy = 1'b0;
      n_zf = 1'b0; n_cf = 1'b0; n_res = 1'b0;
      tid = '0; step = '0;

      // reset held: no strobes even though the state is FETCH_PC
      newTest(8'd0);
      applyStimulus(ex(S_FP, 14'h0, 3'd0, 3'd0, 8'h00, 1'b1));
      applyStimulus(ex(S_FP, 14'h0, 3'd0, 3'd0, 8'h00, 1'b1));

      // MOV mode 010: r3 <= r5
      newTest(8'd1);
      n_rst = 1'b1;
      applyStimulus(ex(S_FP, PINC | IMW, 3'd0, 3'd0, 8'h00, 1'b1));
      n_ins = 16'h2274;
      applyStimulus(ex(S_FI, IRD, 3'd0, 3'd0, 8'h00, 1'b0));
      applyStimulus(ex(S_DE, 14'h0, 3'd0, 3'd0, 8'h00, 1'b1));
      applyStimulus(ex(S_MR, DMW | RRE, 3'd0, 3'd5, 8'h00, 1'b1));
      applyStimulus(ex(S_MW, DMW | RWE, 3'd3, 3'd0, 8'h00, 1'b1));

      // LDR r2,0x3C with d_ready three cycles late
      newTest(8'd2);
      applyStimulus(ex(S_FP, PINC | IMW, 3'd0, 3'd0, 8'h00, 1'b0));
      n_ins = 16'h0A3C;
      applyStimulus(ex(S_FI, IRD, 3'd0, 3'd0, 8'h00, 1'b0));
      applyStimulus(ex(S_DE, 14'h0, 3'd0, 3'd0, 8'h3C, 1'b1));
      for (int i = 0; i < 3; i++)
         applyStimulus(ex(S_MR, DMW | DRD, 3'd0, 3'd0, 8'h3C, 1'b1));
      n_drdy = 1'b1;
      applyStimulus(ex(S_MR, DMW | DRD, 3'd0, 3'd0, 8'h3C, 1'b1));
      n_drdy = 1'b0;
      applyStimulus(ex(S_MW, DMW | RWE, 3'd2, 3'd0, 8'h3C, 1'b1));

      // JZ taken then JZ not taken
      newTest(8'd3);
      applyStimulus(ex(S_FP, PINC | IMW, 3'd0, 3'd0, 8'h00, 1'b0));
      n_ins = 16'h5800;
      applyStimulus(ex(S_FI, IRD, 3'd0, 3'd0, 8'h00, 1'b0));
      applyStimulus(ex(S_DE, 14'h0, 3'd0, 3'd0, 8'h00, 1'b1));
      n_zf = 1'b1;
      applyStimulus(ex(S_JM, PLD | IMW, 3'd0, 3'd0, 8'h00, 1'b1));
      n_zf = 1'b0;
      applyStimulus(ex(S_FI, IRD, 3'd0, 3'd0, 8'h00, 1'b1));
      applyStimulus(ex(S_DE, 14'h0, 3'd0, 3'd0, 8'h00, 1'b1));
      applyStimulus(ex(S_JM, 14'h0, 3'd0, 3'd0, 8'h00, 1'b1));
      applyStimulus(ex(S_FP, PINC | IMW, 3'd0, 3'd0, 8'h00, 1'b1));

      // i_ready stuck low: 15 wait cycles, then HALT with bus_err; stray resume ignored
      newTest(8'd4);
      n_irdy = 1'b0;
      for (int i = 0; i < 15; i++) begin
         n_res = (i == 3);
         applyStimulus(ex(S_FI, IRD, 3'd0, 3'd0, 8'h00, 1'b1));
      end
      n_res = 1'b0;
      applyStimulus(ex(S_HA, HLT | BER, 3'd0, 3'd0, 8'h00, 1'b1));
      applyStimulus(ex(S_HA, HLT | BER, 3'd0, 3'd0, 8'h00, 1'b1));
      n_res = 1'b1;
      applyStimulus(ex(S_HA, HLT | BER, 3'd0, 3'd0, 8'h00, 1'b1));
      n_res = 1'b0;
      applyStimulus(ex(S_FP, PINC | IMW | BER, 3'd0, 3'd0, 8'h00, 1'b1));

      // HLT then resume
      newTest(8'd5);
      n_irdy = 1'b1;
      n_ins  = 16'hF800;
      applyStimulus(ex(S_FI, IRD | BER, 3'd0, 3'd0, 8'h00, 1'b0));
      applyStimulus(ex(S_DE, BER, 3'd0, 3'd0, 8'h00, 1'b1));
      applyStimulus(ex(S_HA, HLT | BER, 3'd0, 3'd0, 8'h00, 1'b1));
      applyStimulus(ex(S_HA, HLT | BER, 3'd0, 3'd0, 8'h00, 1'b1));
      n_res = 1'b1;
      applyStimulus(ex(S_HA, HLT | BER, 3'd0, 3'd0, 8'h00, 1'b1));
      n_res = 1'b0;
      applyStimulus(ex(S_FP, PINC | IMW | BER, 3'd0, 3'd0, 8'h00, 1'b1));

      // ADD r6 <= r6 op r1
      newTest(8'd6);
      n_ins = 16'h2E20;
      applyStimulus(ex(S_FI, IRD | BER, 3'd0, 3'd0, 8'h00, 1'b0));
      applyStimulus(ex(S_DE, BER, 3'd0, 3'd0, 8'h00, 1'b1));
      applyStimulus(ex(S_AF, AEN | RRE | BER, 3'd0, 3'd1, 8'h00, 1'b1));
      applyStimulus(ex(S_AO, AOE | RWE | BER, 3'd6, 3'd0, 8'h00, 1'b1));
      applyStimulus(ex(S_FP, PINC | IMW | BER, 3'd0, 3'd0, 8'h00, 1'b1));

      // LDI: immediate mux select, write port 0
      newTest(8'd7);
      n_ins = 16'h18A5;
      applyStimulus(ex(S_FI, IRD | BER, 3'd0, 3'd0, 8'h00, 1'b0));
      applyStimulus(ex(S_DE, IMM | BER, 3'd0, 3'd0, 8'h00, 1'b1));
      applyStimulus(ex(S_MW, DMW | RWE | IMM | BER, 3'd0, 3'd0, 8'h00, 1'b1));
      applyStimulus(ex(S_FP, PINC | IMW | BER, 3'd0, 3'd0, 8'h00, 1'b0));

      // unknown opcode behaves as NOP
      newTest(8'd8);
      n_ins = 16'hA000;
      applyStimulus(ex(S_FI, IRD | BER, 3'd0, 3'd0, 8'h00, 1'b0));
      applyStimulus(ex(S_DE, BER, 3'd0, 3'd0, 8'h00, 1'b1));
      applyStimulus(ex(S_FP, PINC | IMW | BER, 3'd0, 3'd0, 8'h00, 1'b1));

      // STR r4,0x81 interrupted by reset while waiting in MEM_W
      newTest(8'd9);
      n_ins = 16'h1481;
      applyStimulus(ex(S_FI, IRD | BER, 3'd0, 3'd0, 8'h00, 1'b0));
      applyStimulus(ex(S_DE, BER, 3'd0, 3'd0, 8'h81, 1'b1));
      applyStimulus(ex(S_MW, DMW | DWR | RRE | BER, 3'd0, 3'd4, 8'h81, 1'b1));
      applyStimulus(ex(S_MW, DMW | DWR | RRE | BER, 3'd0, 3'd4, 8'h81, 1'b1));
      n_rst = 1'b0;
      applyStimulus(ex(S_FP, 14'h0, 3'd0, 3'd0, 8'h00, 1'b1));
      applyStimulus(ex(S_FP, 14'h0, 3'd0, 3'd0, 8'h00, 1'b1));
      n_rst = 1'b1;
      applyStimulus(ex(S_FP, PINC | IMW, 3'd0, 3'd0, 8'h00, 1'b1));
      n_irdy = 1'b0;
      applyStimulus(ex(S_FI, IRD, 3'd0, 3'd0, 8'h00, 1'b1));

      @(negedge clk);
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("[TB] FAIL scoreboard_drain pending=%0d want=0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
